// File: rtl/gift_dec_word_loader.sv
// gift_dec_word_loader
// Collects 32-bit stream words into the 128-bit key and the 64-bit ciphertext
// block of the one-round GIFT-64/128 decryption core. Once either buffer is full,
// the loader raises the matching core write strobe. The strobe is held off
// while the core reports busy, because the core drops writes in that state.
// Only WORD_W = 32 is supported. Words arrive most significant first.

module gift_dec_word_loader #(
    parameter int WORD_W     = 32,
    parameter int KEY_WORDS  = 4,
    parameter int DATA_WORDS = 2
) (
    input  logic                           inClk,
    input  logic                           inRstN,
    input  logic                           inWordValid,
    input  logic [WORD_W-1:0]              inWord,
    input  logic                           inWordIsKey,
    output logic                           outWordReady,
    input  logic                           inCoreBusy,
    output logic [WORD_W*KEY_WORDS-1:0]    outKey,
    output logic [WORD_W*DATA_WORDS-1:0]   outData,
    output logic                           outExtKeyWr,
    output logic                           outExtDataWr,
    output logic                           outKeyLoaded,
    output logic                           outErr,
    output logic                           outBusy
);

    localparam int KEY_W  = WORD_W * KEY_WORDS;
    localparam int DATA_W = WORD_W * DATA_WORDS;

    // Counter widths never drop below one bit, even for a single-word buffer.
    localparam int KEY_CNT_W  = (KEY_WORDS  > 1) ? $clog2(KEY_WORDS)  : 1;
    localparam int DATA_CNT_W = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

    localparam logic [KEY_CNT_W-1:0]  KEY_LAST  = KEY_CNT_W'(KEY_WORDS - 1);
    localparam logic [DATA_CNT_W-1:0] DATA_LAST = DATA_CNT_W'(DATA_WORDS - 1);
    localparam logic [KEY_CNT_W-1:0]  KEY_ONE   = KEY_CNT_W'(1);
    localparam logic [DATA_CNT_W-1:0] DATA_ONE  = DATA_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_COLLECT    = 2'd0,
        ST_ISSUE_KEY  = 2'd1,
        ST_ISSUE_DATA = 2'd2
    } loaderState_t;

    loaderState_t            stateR;
    logic [KEY_W-1:0]        keyR;
    logic [DATA_W-1:0]       dataR;
    logic [KEY_CNT_W-1:0]    keyCntR;
    logic [DATA_CNT_W-1:0]   dataCntR;
    logic                    keyLoadedR;
    logic                    errR;

    logic                    keyWrS;
    logic                    dataWrS;
    logic                    readyS;
    logic                    busyS;

    // Decode the handshake ready, the status, and the core write strobes
    // from the current state. Each strobe is also qualified by the live busy
    // flag, so it fires in the first idle cycle. Reset masks both strobes
    // because a reset edge aborts the pending issue.
    always_comb begin
        keyWrS  = 1'b0;
        dataWrS = 1'b0;
        readyS  = 1'b0;
        busyS   = 1'b0;
        case (stateR)
            ST_COLLECT: begin
                readyS = 1'b1;
                busyS  = 1'b0;
            end
            ST_ISSUE_KEY: begin
                busyS = 1'b1;
                if (inRstN && !inCoreBusy) begin
                    keyWrS = 1'b1;
                end else begin
                    keyWrS = 1'b0;
                end
            end
            ST_ISSUE_DATA: begin
                busyS = 1'b1;
                if (inRstN && !inCoreBusy) begin
                    dataWrS = 1'b1;
                end else begin
                    dataWrS = 1'b0;
                end
            end
            default: begin
                keyWrS  = 1'b0;
                dataWrS = 1'b0;
                readyS  = 1'b0;
                busyS   = 1'b1;
            end
        endcase
    end

    // Loader state machine. It assembles the key and data buffers, keeps a
    // separate word counter for each stream, and returns to collection after
    // each strobe. A data word that arrives before any key has been loaded is
    // consumed without being stored, and is flagged on the error pulse.
    always_ff @(posedge inClk) begin
        if (!inRstN) begin
            stateR     <= ST_COLLECT;
            keyR       <= '0;
            dataR      <= '0;
            keyCntR    <= '0;
            dataCntR   <= '0;
            keyLoadedR <= 1'b0;
            errR       <= 1'b0;
        end else begin
            errR <= 1'b0;
            case (stateR)
                ST_COLLECT: begin
                    if (inWordValid) begin
                        if (inWordIsKey) begin
                            keyR <= {keyR[KEY_W-WORD_W-1:0], inWord};
                            if (keyCntR == KEY_LAST) begin
                                keyCntR <= '0;
                                stateR  <= ST_ISSUE_KEY;
                            end else begin
                                keyCntR <= keyCntR + KEY_ONE;
                            end
                        end else if (keyLoadedR) begin
                            dataR <= {dataR[DATA_W-WORD_W-1:0], inWord};
                            if (dataCntR == DATA_LAST) begin
                                dataCntR <= '0;
                                stateR   <= ST_ISSUE_DATA;
                            end else begin
                                dataCntR <= dataCntR + DATA_ONE;
                            end
                        end else begin
                            errR <= 1'b1;
                        end
                    end
                end
                ST_ISSUE_KEY: begin
                    if (!inCoreBusy) begin
                        keyLoadedR <= 1'b1;
                        stateR     <= ST_COLLECT;
                    end
                end
                ST_ISSUE_DATA: begin
                    if (!inCoreBusy) begin
                        stateR <= ST_COLLECT;
                    end
                end
                default: begin
                    stateR <= ST_COLLECT;
                end
            endcase
        end
    end

    assign outWordReady = readyS;
    assign outBusy      = busyS;
    assign outExtKeyWr  = keyWrS;
    assign outExtDataWr = dataWrS;
    assign outKey       = keyR;
    assign outData      = dataR;
    assign outKeyLoaded = keyLoadedR;
    assign outErr       = errR;

endmodule
